// File: rtl/dac_scheduler.sv
// dac_scheduler: paces samples from two requesters into a serial DAC at a fixed
// sample period. Requesters are served round-robin. When nobody is valid at a
// sample slot, an underrun is flagged.
// Optional feature (macro DAC_HOLD_LAST_EN): on underrun, resend the last
// transmitted sample instead of skipping the slot.
module dac_scheduler #(
    parameter int unsigned PERIOD = 40,
    parameter int unsigned DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          dac_start,
    output logic [DW-1:0] dac_data,
    input  logic          dac_done,
    output logic          grant_id,
    output logic          busy,
    output logic          underrun,
    output logic          overrun
);

    localparam int unsigned     CntW   = $clog2(PERIOD);
    localparam logic [CntW-1:0] CntMax = CntW'(PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StSend,
        StWaitDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ptr_q, ptr_d;
    logic            grant_q, grant_d;
    // Last transmitted sample; doubles as the held DAC output.
    logic [DW-1:0]   sample_q, sample_d;

    logic tick;
    logic any_valid;
    logic winner;
    logic arb_slot;

    assign tick      = (cnt_q == CntMax);
    assign any_valid = req0_valid | req1_valid;
    // Pointer only matters when both are valid; a lone requester always wins.
    assign winner    = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    // Free-running sample-period counter, wraps at PERIOD-1.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    // Next-state logic: normal sequencing, then tick handling overrides it.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        sample_d = sample_q;
        underrun = 1'b0;
        overrun  = 1'b0;
        // A tick that lands on the frame-complete cycle is as good as an idle tick.
        arb_slot = (state_q == StIdle) || ((state_q == StWaitDone) && dac_done);

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StGrant: begin
                state_d  = StSend;
                sample_d = grant_q ? req1_data : req0_data;
            end
            StSend: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (dac_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (tick) begin
            if (arb_slot) begin
                if (any_valid) begin
                    state_d = StGrant;
                    grant_d = winner;
                    ptr_d   = ~winner;
                end else begin
                    underrun = 1'b1;
`ifdef DAC_HOLD_LAST_EN
                    // sample_q still holds the previous sample, so just relaunch it.
                    state_d  = StSend;
`else
                    state_d  = StIdle;
`endif
                end
            end else begin
                // Slot missed while a frame is still in flight: drop the tick.
                overrun = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= 1'b0;
            grant_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            sample_q <= sample_d;
        end
    end

    assign req0_ready = (state_q == StGrant) && !grant_q;
    assign req1_ready = (state_q == StGrant) && grant_q;
    assign dac_start  = (state_q == StSend);
    assign dac_data   = sample_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_dac_scheduler.sv
// Bench for dac_scheduler: a directed vector table, hand-written overrun and
// mid-frame reset sequences, then randomized traffic against a timestamp model.
`timescale 1ns/1ps
module tb_dac_scheduler;

    localparam int unsigned PERIOD = 40;
    localparam int unsigned DW     = 16;
    localparam int          P      = 40;
`ifdef DAC_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          dac_start;
    logic [DW-1:0] dac_data;
    logic          dac_done = 1'b0;
    logic          grant_id;
    logic          busy;
    logic          underrun;
    logic          overrun;

    always #5 clk = ~clk;

    dac_scheduler #(
        .PERIOD(PERIOD),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .dac_start (dac_start),
        .dac_data  (dac_data),
        .dac_done  (dac_done),
        .grant_id  (grant_id),
        .busy      (busy),
        .underrun  (underrun),
        .overrun   (overrun)
    );

    int checks = 0;
    int errors = 0;

    // Cycle index since the last clock edge that saw rst high; tick is at index%P == P-1.
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        bit          v0;
        bit          v1;
        logic [15:0] d0;
        logic [15:0] d1;
        bit          e_und;
        bit          e_gid;
        bit          e_start;
        logic [15:0] e_data;
    } vec_t;
    vec_t vecs [9];

    // Random-phase model state.
    bit          rq_v [2];
    logic [15:0] rq_d [2];
    bit          prev_rdy [2];
    bit          prev_start;
    int          done_in;
    bit          dn;
    int          now;
    bit          tick;
    bit          m_busy;
    bit          accept;
    bit          e_start;
    logic [15:0] e_data;
    bit          m_ptr;
    bit          m_gid;
    bit          m_waiting;
    bit          w;
    int          rd_t;
    bit          rd_id;
    int          st_t;
    logic [15:0] st_data;
    logic [15:0] last_sent;
    int          ovr;
    int          starts;
    int          n;
    bit          seen;
    bit          drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next cycle with the given counter phase, then settle.
    task automatic wait_phase(input int ph);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((cyc % P) != ph && k < 3 * P);
        if ((cyc % P) != ph) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: got phase %0d expected %0d", cyc % P, ph);
        end
        #1;
    endtask

    // Frame already launched: a few busy cycles, then one dac_done pulse.
    task automatic finish_frame();
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("frame_busy", busy, 1);
        end
        @(negedge clk);
        dac_done = 1'b1;
        #1;
        chk("done_cycle_busy", busy, 1);
        @(negedge clk);
        dac_done = 1'b0;
        #1;
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pointer starts at 0 after reset; every grant points it at the other side.
        vecs[0] = '{1'b1, 1'b0, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5};
        vecs[1] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[2] = '{1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111};
        vecs[4] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, 1'b1, 16'h2222};
        vecs[5] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111};
        vecs[6] = '{1'b1, 1'b0, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, HOLD, 16'hA5A5};
        vecs[8] = '{1'b1, 1'b1, 16'h3333, 16'h4444, 1'b0, 1'b1, 1'b1, 16'h4444};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_start", dac_start, 0);
        chk("rst_data", dac_data, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Directed vectors, one sample slot each.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req0_valid = vecs[i].v0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_data  = vecs[i].d1;
            wait_phase(P - 1);
            chk("tick_busy", busy, 0);
            chk("tick_underrun", underrun, vecs[i].e_und);
            chk("tick_overrun", overrun, 0);
            @(negedge clk);
            #1;
            if (vecs[i].e_und) begin
                chk("und_ready0", req0_ready, 0);
                chk("und_ready1", req1_ready, 0);
                chk("und_start", dac_start, vecs[i].e_start);
                chk("und_data", dac_data, vecs[i].e_data);
                chk("und_gid", grant_id, vecs[i].e_gid);
                if (vecs[i].e_start) finish_frame();
                else chk("und_idle", busy, 0);
            end else begin
                chk("grant_ready0", req0_ready, !vecs[i].e_gid);
                chk("grant_ready1", req1_ready, vecs[i].e_gid);
                chk("grant_start", dac_start, 0);
                chk("grant_busy", busy, 1);
                @(negedge clk);
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                #1;
                chk("send_ready0", req0_ready, 0);
                chk("send_ready1", req1_ready, 0);
                chk("send_start", dac_start, 1);
                chk("send_data", dac_data, vecs[i].e_data);
                chk("send_gid", grant_id, vecs[i].e_gid);
                finish_frame();
            end
        end

        // Withheld dac_done: exactly one overrun at the next tick, still waiting.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 16'h5555;
        wait_phase(P - 1);
        chk("seqA_underrun", underrun, 0);
        @(negedge clk);
        #1;
        chk("seqA_ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("seqA_start", dac_start, 1);
        chk("seqA_data", dac_data, 16'h5555);
        ovr    = 0;
        starts = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (overrun) ovr++;
            if (dac_start) starts++;
            if ((cyc % P) == P - 1) begin
                chk("seqA_overrun_at_tick", overrun, 1);
                chk("seqA_busy_at_tick", busy, 1);
            end
        end
        chk("seqA_overrun_count", ovr, 1);
        chk("seqA_no_start", starts, 0);
        chk("seqA_still_waiting", busy, 1);

        // dac_done coincident with tick: arbitrate at once, no overrun.
        req1_valid = 1'b1;
        req1_data  = 16'h6666;
        wait_phase(P - 2);
        @(negedge clk);
        dac_done = 1'b1;
        #1;
        chk("coinc_is_tick", (cyc % P), P - 1);
        chk("coinc_overrun", overrun, 0);
        chk("coinc_underrun", underrun, 0);
        @(negedge clk);
        dac_done = 1'b0;
        #1;
        chk("coinc_ready1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("coinc_start", dac_start, 1);
        chk("coinc_data", dac_data, 16'h6666);
        chk("coinc_gid", grant_id, 1);
        finish_frame();

        // Reset in the middle of WAIT_DONE with a requester still valid.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 16'h7777;
        wait_phase(P - 1);
        @(negedge clk);
        #1;
        chk("seqB_ready0", req0_ready, 1);
        @(negedge clk);
        #1;
        chk("seqB_start", dac_start, 1);
        chk("seqB_data", dac_data, 16'h7777);
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        dac_done = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_ready0", req0_ready, 0);
        chk("mid_rst_ready1", req1_ready, 0);
        chk("mid_rst_start", dac_start, 0);
        chk("mid_rst_data", dac_data, 0);
        chk("mid_rst_gid", grant_id, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_overrun", overrun, 0);
        dac_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            dac_done = ~dac_done;
            #1;
            chk("rst_hold_busy", busy, 0);
            chk("rst_hold_ready0", req0_ready, 0);
        end
        // Release: the counter is 0 in this cycle, tick falls at index P-1,
        // dac_start two cycles after that (42 cycles counting the last rst cycle).
        @(negedge clk);
        rst      = 1'b0;
        dac_done = 1'b0;
        n    = 0;
        seen = 1'b0;
        drop = 1'b0;
        while (!seen && n < 3 * P) begin
            @(negedge clk);
            n++;
            if (drop) req0_valid = 1'b0;
            #1;
            if (req0_ready) drop = 1'b1;
            if (dac_start) seen = 1'b1;
        end
        chk("rst_release_to_start", n, P + 1);
        chk("rst_release_data", dac_data, 16'h7777);
        chk("rst_release_gid", grant_id, 0);
        finish_frame();

        // Randomized traffic against the timestamp model.
        @(negedge clk);
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        dac_done   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        rq_v[0]     = 1'b0;
        rq_v[1]     = 1'b0;
        rq_d[0]     = '0;
        rq_d[1]     = '0;
        prev_rdy[0] = 1'b0;
        prev_rdy[1] = 1'b0;
        prev_start  = 1'b0;
        done_in     = -1;
        m_ptr       = 1'b0;
        m_gid       = 1'b0;
        m_waiting   = 1'b0;
        rd_t        = -10;
        rd_id       = 1'b0;
        st_t        = -10;
        st_data     = '0;
        last_sent   = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (prev_rdy[k]) rq_v[k] = 1'b0;
                if (!rq_v[k] && $urandom_range(0, 59) == 0) begin
                    rq_v[k] = 1'b1;
                    rq_d[k] = 16'($urandom);
                end
            end
            req0_valid = rq_v[0];
            req0_data  = rq_d[0];
            req1_valid = rq_v[1];
            req1_data  = rq_d[1];
            // Serializer: random frame length, occasional stray done when idle.
            dn = 1'b0;
            if (prev_start) done_in = int'($urandom_range(0, 59));
            if (done_in == 0) begin
                dn      = 1'b1;
                done_in = -1;
            end else if (done_in > 0) begin
                done_in--;
            end else if ($urandom_range(0, 49) == 0) begin
                dn = 1'b1;
            end
            dac_done = dn;
            #1;

            now     = cyc;
            tick    = ((now % P) == P - 1);
            m_busy  = (rd_t == now) || (st_t == now) || m_waiting;
            accept  = tick && (!m_busy || (m_waiting && dn));
            e_start = (st_t == now);
            e_data  = e_start ? st_data : last_sent;
            chk("rnd_ready0", req0_ready, (rd_t == now) && (rd_id == 1'b0));
            chk("rnd_ready1", req1_ready, (rd_t == now) && (rd_id == 1'b1));
            chk("rnd_start", dac_start, e_start);
            chk("rnd_data", dac_data, e_data);
            chk("rnd_gid", grant_id, m_gid);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_underrun", underrun, accept && !rq_v[0] && !rq_v[1]);
            chk("rnd_overrun", overrun, tick && !accept);

            if (m_waiting && dn) m_waiting = 1'b0;
            if (e_start) begin
                last_sent = st_data;
                m_waiting = 1'b1;
            end
            if (accept) begin
                if (rq_v[0] || rq_v[1]) begin
                    w       = (rq_v[0] && rq_v[1]) ? m_ptr : rq_v[1];
                    m_ptr   = !w;
                    m_gid   = w;
                    rd_t    = now + 1;
                    rd_id   = w;
                    st_t    = now + 2;
                    st_data = w ? rq_d[1] : rq_d[0];
                end else if (HOLD) begin
                    st_t    = now + 1;
                    st_data = last_sent;
                end
            end
            prev_rdy[0] = req0_ready;
            prev_rdy[1] = req1_ready;
            prev_start  = dac_start;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_scheduler.md
DAC_SCHEDULER -- requirements
Module: dac_scheduler

Interface
REQ-001 SHALL have parameter PERIOD, default 40, sample period in clk cycles (400 ns at 100 MHz, 2.5 MSPS); legal range 8..1023.
REQ-002 SHALL have parameter DW, default 16, sample width in bits.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester k holds a sample.
REQ-006 SHALL have ports req0_data / req1_data  input  DW  unsigned sample of requester k.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  sample of requester k accepted this cycle.
REQ-008 SHALL have port dac_start  output  1  one-cycle pulse that launches one serial DAC conversion.
REQ-009 SHALL have port dac_data  output  DW  sample for the serializer; valid while dac_start is high and held until the next dac_start.
REQ-010 SHALL have port dac_done  input  1  one-cycle pulse from the serializer when the frame is complete.
REQ-011 SHALL have port grant_id  output  1  requester that owns the current or last transfer.
REQ-012 SHALL have ports busy, underrun, overrun  output  1 each: busy is high when the state is not IDLE; underrun and overrun are one-cycle event pulses.

Function
REQ-013 SHALL run a free counter 0..PERIOD-1 that wraps to 0; tick is 1 in the cycle where the counter equals PERIOD-1.
REQ-014 SHALL implement the states IDLE, GRANT, SEND and WAIT_DONE.
REQ-015 SHALL arbitrate in IDLE on tick with at least one valid: go to GRANT, register the winner in grant_id, and go to SEND the next cycle.
REQ-016 SHALL arbitrate round-robin: with both valid, grant the requester the pointer names; after each grant, point the pointer at the other requester; with one valid, grant that requester regardless of the pointer.
REQ-017 SHALL in GRANT assert ready only for grant_id, for exactly one cycle, and capture its data; requesters hold valid and data stable until ready.
REQ-018 SHALL in SEND pulse dac_start for one cycle with dac_data equal to the captured sample, then enter WAIT_DONE.
REQ-019 SHALL leave WAIT_DONE on dac_done and enter IDLE.
REQ-020 SHALL treat tick and dac_done in the same WAIT_DONE cycle as a tick in IDLE: arbitrate in that cycle with no overrun.
REQ-021 SHALL on any other tick while not in IDLE pulse overrun, discard the tick and leave the state unchanged.
REQ-022 SHALL ignore dac_done outside WAIT_DONE.
REQ-023 SHALL have a latency of 2 cycles from tick to dac_start (tick at t, GRANT at t+1, dac_start at t+2).
REQ-024 SHALL on tick in IDLE with no valid pulse underrun; the behaviour that follows is set by REQ-028.

Reset
REQ-025 SHALL on rst, from any state including mid-frame, next cycle put: state IDLE, counter 0, pointer and grant_id 0, last-sample register 0, dac_data 0, and every ready, dac_start, underrun, overrun and busy 0.
REQ-026 SHALL while rst is high ignore valid and dac_done; the first tick after rst is released falls PERIOD cycles later.

Configuration
REQ-027 SHALL use the macro DAC_HOLD_LAST_EN.
REQ-028 SHALL with DAC_HOLD_LAST_EN defined, on underrun, go from IDLE directly to SEND and resend the last transmitted sample (0 after reset); without it, on underrun, stay in IDLE and issue no dac_start.

Verification
REQ-029 SHALL cover: PERIOD=40, req0 only with valid and 16'hA5A5 -> req0_ready 1 cycle after tick, dac_start 2 cycles after tick with dac_data 16'hA5A5, busy until dac_done.
REQ-030 SHALL cover: both valid every period, with data 16'h1111 and 16'h2222 -> dac_data alternates 1111, 2222, 1111, and grant_id alternates 0, 1, 0.
REQ-031 SHALL cover: dac_done withheld for 50 cycles -> overrun pulses once at the next tick and the state stays WAIT_DONE; tick coincident with dac_done -> no overrun and a new dac_start 2 cycles later.
REQ-032 SHALL cover: no valid at tick -> underrun pulses; with DAC_HOLD_LAST_EN the previous 16'hA5A5 is resent, and without it there is no dac_start.
REQ-033 SHALL cover: rst asserted during WAIT_DONE -> all outputs 0 next cycle, and the first dac_start comes 42 cycles after rst is released if a requester is valid.
